// File: rtl/monitor_scheduler.sv
// monitor_scheduler
//   Buffers incoming events in a small FIFO and issues them to a downstream
//   monitor in fixed-length slots. A free-running period timer raises
//   periodic evaluation ticks that share the same slots. Each slot is one
//   ISSUE cycle followed by GAP_CYCLES idle WAIT cycles, which gives the
//   monitor pipeline time to settle. A tick that cannot be delivered before
//   the next one arrives is reported as a miss.
//
//   State table
//     state   | meaning
//     IDLE    | nothing to issue (or en=0); waiting for an event or a tick
//     ISSUE   | one-cycle slot: present FIFO head and/or tick to the monitor
//     WAIT    | GAP_CYCLES cycles of settle time before the next slot
//
//   Ports
//     clk            clock; all state changes on the rising edge
//     rst            asynchronous active-low reset
//     en             global enable; freezes timer, FSM and WAIT countdown
//     in_valid       producer offers an event
//     in_data        event value (signed, DATA_W bits)
//     in_ready       registered FIFO-not-full
//     mon_input      value to the monitor, zero unless mon_new_input
//     mon_new_input  one-cycle event-arrival pulse
//     mon_tick       one-cycle periodic evaluation pulse
//     busy           FSM is not IDLE
//     tick_miss      one-cycle pulse when a pending tick is overwritten
//     miss_count     saturating count of lost ticks
module monitor_scheduler #(
    parameter int DATA_W        = 64,
    parameter int FIFO_DEPTH    = 4,
    parameter int PERIOD_CYCLES = 1000,
    parameter int GAP_CYCLES    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] mon_input,
    output logic              mon_new_input,
    output logic              mon_tick,
    output logic              busy,
    output logic              tick_miss,
    output logic [7:0]        miss_count
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [TW-1:0] T_ONE    = TW'(1);
    localparam logic [TW-1:0] T_LAST   = TW'(PERIOD_CYCLES - 1);
    localparam logic [GW-1:0] G_ONE    = GW'(1);
    localparam logic [GW-1:0] G_LOAD   = GW'(GAP_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic [AW:0]       count, count_next;
    logic [TW-1:0]     timer;
    logic [GW-1:0]     wait_cnt;
    logic [1:0]        state;
    logic              tick_pending;
    logic              issue_ev, issue_tk;
    logic              wr_en, pop, fifo_empty, work;
    logic              wrap, tick_consume, miss;

    assign fifo_empty   = (count == '0);
    assign wr_en        = in_valid && in_ready;
    assign pop          = (state == S_ISSUE) && en && issue_ev;
    assign tick_consume = (state == S_ISSUE) && en && issue_tk;
    assign wrap         = en && (timer == T_LAST);
    // A consume on the same edge as the wrap frees the slot for the new tick.
    assign miss         = wrap && tick_pending && !tick_consume;
    assign work         = !fifo_empty || tick_pending;

    always_comb begin
        count_next = count;
        if (wr_en && !pop)
            count_next = count + CNT_ONE;
        else if (!wr_en && pop)
            count_next = count - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b1;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            count    <= count_next;
            in_ready <= (count_next != CNT_FULL);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer        <= '0;
            tick_pending <= 1'b0;
            tick_miss    <= 1'b0;
            miss_count   <= '0;
        end else begin
            if (en)
                timer <= wrap ? '0 : timer + T_ONE;
            // A new tick wins over the clear of the one just consumed.
            if (wrap)
                tick_pending <= 1'b1;
            else if (tick_consume)
                tick_pending <= 1'b0;
            tick_miss <= miss;
            if (miss && (miss_count != 8'hFF))
                miss_count <= miss_count + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            issue_ev <= 1'b0;
            issue_tk <= 1'b0;
        end else if (en) begin
            unique case (state)
                S_IDLE: begin
                    if (work) begin
                        state    <= S_ISSUE;
                        issue_ev <= !fifo_empty;
                        issue_tk <= tick_pending;
                    end
                end
                S_ISSUE: begin
                    state    <= S_WAIT;
                    wait_cnt <= G_LOAD;
                end
                S_WAIT: begin
                    // The IDLE decision is folded into the last WAIT cycle so
                    // back-to-back slots are exactly 1+GAP_CYCLES apart.
                    if (wait_cnt == '0) begin
                        if (work) begin
                            state    <= S_ISSUE;
                            issue_ev <= !fifo_empty;
                            issue_tk <= tick_pending;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - G_ONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mon_new_input = (state == S_ISSUE) && issue_ev && en;
    assign mon_tick      = (state == S_ISSUE) && issue_tk && en;
    assign mon_input     = mon_new_input ? mem[rd_ptr] : '0;
    assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_monitor_scheduler.sv
module tb_monitor_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        en_a, vld_a, rdy_a, new_a, tick_a, busy_a, miss_a;
    logic [63:0] data_a, inp_a;
    logic [7:0]  mcnt_a;

    logic        en_b, vld_b, rdy_b, new_b, tick_b, busy_b, miss_b;
    logic [63:0] data_b, inp_b;
    logic [7:0]  mcnt_b;

    monitor_scheduler #(.DATA_W(64), .FIFO_DEPTH(4), .PERIOD_CYCLES(10), .GAP_CYCLES(3)) dut_a (
        .clk(clk), .rst(rst_n), .en(en_a), .in_valid(vld_a), .in_data(data_a),
        .in_ready(rdy_a), .mon_input(inp_a), .mon_new_input(new_a), .mon_tick(tick_a),
        .busy(busy_a), .tick_miss(miss_a), .miss_count(mcnt_a));

    monitor_scheduler #(.DATA_W(64), .FIFO_DEPTH(4), .PERIOD_CYCLES(2), .GAP_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst_n), .en(en_b), .in_valid(vld_b), .in_data(data_b),
        .in_ready(rdy_b), .mon_input(inp_b), .mon_new_input(new_b), .mon_tick(tick_b),
        .busy(busy_b), .tick_miss(miss_b), .miss_count(mcnt_b));

    // cyc = number of rising edges since reset release
    int cyc = 0;
    always @(posedge clk) if (rst_n) cyc <= cyc + 1;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        int          c;
        logic        nw;
        logic [63:0] d;
        logic        tk;
    } slot_t;

    slot_t exp_q[$];
    slot_t mon_s;
    bit    mon_a_on = 1'b0;
    int    busy_a_cnt = 0;
    int    miss_b_pulses = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int c, input logic nw, input logic [63:0] d, input logic tk);
        slot_t s;
        s.c = c; s.nw = nw; s.d = d; s.tk = tk;
        exp_q.push_back(s);
    endtask

    // returns 1 ns after rising edge k
    task automatic at_cyc(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // returns on the falling edge inside cycle k
    task automatic at_neg(input int k);
        at_cyc(k);
        @(negedge clk);
    endtask

    // scoreboard monitor for dut_a
    always @(negedge clk) begin
        if (mon_a_on && rst_n) begin
            if (!new_a)
                check("a_mon_input_zero", inp_a, 64'h0);
            if (new_a || tick_a) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL a_unexpected_slot at cyc %0d: got new=%0b tick=%0b data=0x%0h, expected no slot",
                             cyc, new_a, tick_a, inp_a);
                end else begin
                    mon_s = exp_q.pop_front();
                    check("a_slot_cycle", 64'(cyc), 64'(mon_s.c));
                    check("a_slot_new", {63'h0, new_a}, {63'h0, mon_s.nw});
                    check("a_slot_data", inp_a, mon_s.d);
                    check("a_slot_tick", {63'h0, tick_a}, {63'h0, mon_s.tk});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && cyc >= 1 && cyc <= 9 && busy_a)
            busy_a_cnt <= busy_a_cnt + 1;
        if (rst_n && miss_b)
            miss_b_pulses <= miss_b_pulses + 1;
    end

    task automatic seq_a();
        logic [63:0] dv [6];
        logic        acc;
        int          i;
        dv[0] = 64'h11;
        dv[1] = 64'hFFFF_FFFF_FFFF_FFFE;
        dv[2] = 64'h8000_0000_0000_0000;
        dv[3] = 64'h7FFF_FFFF_FFFF_FFFF;
        dv[4] = 64'h3;
        dv[5] = 64'hDEAD_BEEF;

        // single event, then first periodic tick
        push(3, 1'b1, 64'd5, 1'b0);
        push(11, 1'b0, 64'h0, 1'b1);
        at_cyc(1);  vld_a = 1'b1; data_a = 64'd5;
        at_cyc(2);  vld_a = 1'b0; data_a = '0;
        at_cyc(10);
        check("a_busy_cycles_single", 64'(busy_a_cnt), 64'd4);

        // event and tick pending together
        push(21, 1'b1, 64'h77, 1'b1);
        at_cyc(19); vld_a = 1'b1; data_a = 64'h77;
        at_cyc(20); vld_a = 1'b0; data_a = '0;

        // six back-to-back events against a four-entry buffer
        push(27, 1'b1, dv[0], 1'b0);
        push(31, 1'b1, dv[1], 1'b1);
        push(35, 1'b1, dv[2], 1'b0);
        push(39, 1'b1, dv[3], 1'b0);
        push(43, 1'b1, dv[4], 1'b1);
        push(47, 1'b1, dv[5], 1'b0);
        push(51, 1'b0, 64'h0, 1'b1);
        at_cyc(25);
        i = 0;
        while (i < 6) begin
            vld_a  = 1'b1;
            data_a = dv[i];
            acc    = rdy_a;
            @(posedge clk);
            #1;
            if (cyc == 30) check("a_in_ready_full_30", {63'h0, rdy_a}, 64'h0);
            if (cyc == 31) check("a_in_ready_full_31", {63'h0, rdy_a}, 64'h0);
            if (cyc == 32) check("a_in_ready_after_pop", {63'h0, rdy_a}, 64'h1);
            if (acc) i++;
        end
        vld_a = 1'b0; data_a = '0;

        // en low for 25 edges with events buffered; timer resumes at 5
        push(81, 1'b1, 64'h1A, 1'b0);
        push(85, 1'b1, 64'h2B, 1'b0);
        push(89, 1'b0, 64'h0, 1'b1);
        push(96, 1'b0, 64'h0, 1'b1);
        push(106, 1'b0, 64'h0, 1'b1);
        push(116, 1'b0, 64'h0, 1'b1);
        at_cyc(55); en_a = 1'b0; vld_a = 1'b1; data_a = 64'h1A;
        at_cyc(56); data_a = 64'h2B;
        at_cyc(57); vld_a = 1'b0; data_a = '0;
        at_cyc(60);
        check("a_busy_frozen_idle", {63'h0, busy_a}, 64'h0);
        check("a_in_ready_two_buffered", {63'h0, rdy_a}, 64'h1);
        at_cyc(80); en_a = 1'b1;
        at_cyc(120);
        mon_a_on = 1'b0;
    endtask

    task automatic seq_b();
        at_neg(3);
        check("b_first_tick", {63'h0, tick_b}, 64'h1);
        check("b_first_tick_no_event", {63'h0, new_b}, 64'h0);
        at_neg(4);
        check("b_tick_one_cycle", {63'h0, tick_b}, 64'h0);
        check("b_busy_wait", {63'h0, busy_b}, 64'h1);
        at_neg(6);
        check("b_first_miss_pulse", {63'h0, miss_b}, 64'h1);
        check("b_miss_count_1", 64'(mcnt_b), 64'd1);
        at_neg(7);
        check("b_miss_one_cycle", {63'h0, miss_b}, 64'h0);
        check("b_tick_after_miss", {63'h0, tick_b}, 64'h1);
        at_neg(10);
        check("b_miss_count_2", 64'(mcnt_b), 64'd2);
        at_neg(1018);
        check("b_miss_count_254", 64'(mcnt_b), 64'd254);
        at_neg(1022);
        check("b_miss_count_255", 64'(mcnt_b), 64'd255);
        at_neg(1030);
        check("b_miss_count_saturated", 64'(mcnt_b), 64'd255);
        check("b_miss_pulse_when_saturated", {63'h0, miss_b}, 64'h1);
        at_neg(1031);
        check("b_miss_pulse_total", 64'(miss_b_pulses), 64'd257);

        // buffer events, then reset in the middle of WAIT
        at_cyc(1035); vld_b = 1'b1; data_b = 64'd9;
        at_cyc(1038); vld_b = 1'b0; data_b = '0;
        at_neg(1039);
        check("b_event_slot_new", {63'h0, new_b}, 64'h1);
        check("b_event_slot_data", inp_b, 64'd9);
        check("b_event_slot_tick", {63'h0, tick_b}, 64'h1);
        at_neg(1041);
        check("b_busy_before_reset", {63'h0, busy_b}, 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("b_rst_in_ready", {63'h0, rdy_b}, 64'h1);
        check("b_rst_busy", {63'h0, busy_b}, 64'h0);
        check("b_rst_new", {63'h0, new_b}, 64'h0);
        check("b_rst_tick", {63'h0, tick_b}, 64'h0);
        check("b_rst_input", inp_b, 64'h0);
        check("b_rst_miss", {63'h0, miss_b}, 64'h0);
        check("b_rst_miss_count", 64'(mcnt_b), 64'd0);
        repeat (3) @(negedge clk);
        check("b_rst_held_busy", {63'h0, busy_b}, 64'h0);
        check("b_rst_held_tick", {63'h0, tick_b}, 64'h0);
        rst_n = 1'b1;
        at_neg(1042);
        check("b_post_rst_no_event", {63'h0, new_b}, 64'h0);
        check("b_post_rst_idle", {63'h0, busy_b}, 64'h0);
        at_neg(1043);
        check("b_post_rst_no_event_2", {63'h0, new_b}, 64'h0);
        check("b_post_rst_no_tick", {63'h0, tick_b}, 64'h0);
        at_neg(1044);
        check("b_post_rst_first_tick", {63'h0, tick_b}, 64'h1);
        check("b_post_rst_tick_only", {63'h0, new_b}, 64'h0);
        check("b_post_rst_miss_count", 64'(mcnt_b), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit reached, expected bench to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        en_a   = 1'b1; vld_a = 1'b0; data_a = '0;
        en_b   = 1'b1; vld_b = 1'b0; data_b = '0;
        repeat (2) @(negedge clk);
        check("a_rst_in_ready", {63'h0, rdy_a}, 64'h1);
        check("a_rst_busy", {63'h0, busy_a}, 64'h0);
        check("a_rst_new", {63'h0, new_a}, 64'h0);
        check("a_rst_tick", {63'h0, tick_a}, 64'h0);
        check("a_rst_input", inp_a, 64'h0);
        check("a_rst_miss", {63'h0, miss_a}, 64'h0);
        check("a_rst_miss_count", 64'(mcnt_a), 64'd0);
        rst_n    = 1'b1;
        mon_a_on = 1'b1;
        fork
            seq_a();
            seq_b();
        join
        check("a_scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/monitor_scheduler.md
MONITOR_SCHEDULER -- requirements
Module: monitor_scheduler

Interface
REQ-001 SHALL have parameter DATA_W, default 64, width of input event value (signed).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, input event buffer entries (power of two, >=2).
REQ-003 SHALL have parameter PERIOD_CYCLES, default 1000, clock cycles between periodic evaluation ticks (>=2).
REQ-004 SHALL have parameter GAP_CYCLES, default 3, idle cycles after each issue slot (>=1) covering the monitor evaluation pipeline.
REQ-005 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-006 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have port en  input  1  global enable.
REQ-008 SHALL have port in_valid  input  1  producer offers an event.
REQ-009 SHALL have port in_data  input  DATA_W  event value.
REQ-010 SHALL have port in_ready  output  1  buffer can accept an event.
REQ-011 SHALL have port mon_input  output  DATA_W  value driven to the monitor input.
REQ-012 SHALL have port mon_new_input  output  1  one-cycle event-arrival pulse to the monitor.
REQ-013 SHALL have port mon_tick  output  1  one-cycle periodic evaluation pulse to the monitor.
REQ-014 SHALL have port busy  output  1  high whenever the FSM is not IDLE.
REQ-015 SHALL have port tick_miss  output  1  one-cycle pulse when a tick is lost.
REQ-016 SHALL have port miss_count  output  8  saturating count of lost ticks.

Function
REQ-017 SHALL accept an event on a rising edge when in_valid and in_ready are both 1; in_ready = FIFO not full, registered; no write occurs when full, even if a pop happens that cycle.
REQ-018 SHALL count a period timer 0..PERIOD_CYCLES-1, advancing only when en=1; on wrap to 0, tick_pending is set.
REQ-019 SHALL, if the timer wraps while tick_pending is still set and not consumed that same edge, pulse tick_miss for one cycle and increment miss_count, saturating at 255.
REQ-020 SHALL implement FSM states IDLE, ISSUE, WAIT.
REQ-021 IDLE -> ISSUE when en=1 and (FIFO non-empty or tick_pending); otherwise stay IDLE.
REQ-022 In ISSUE (exactly one cycle): mon_new_input=1 with mon_input = FIFO head if the FIFO was non-empty on entry; mon_tick=1 if tick_pending was set on entry; both may be 1 in the same slot; consumed entry popped and tick_pending cleared on leaving ISSUE.
REQ-023 ISSUE -> WAIT; WAIT holds GAP_CYCLES cycles, then -> IDLE.
REQ-024 SHALL drive mon_input = 0 whenever mon_new_input = 0.
REQ-025 Latency: an event written at edge N into an empty FIFO with the FSM in IDLE SHALL appear on mon_new_input during cycle N+1..N+2.
REQ-026 Events SHALL be issued in arrival order, one per slot; the minimum slot spacing is 1+GAP_CYCLES cycles.
REQ-027 en=0: timer, FSM, and WAIT countdown frozen; mon_new_input and mon_tick forced 0; FIFO writes still accepted; tick_miss is not generated.
REQ-028 A tick that becomes pending during WAIT SHALL be issued at the next slot, not dropped.

Reset
REQ-029 On rst=0, immediately and asynchronously: FSM=IDLE, FIFO empty, timer=0, tick_pending=0, miss_count=0.
REQ-030 During and after reset: in_ready=1, mon_input=0, mon_new_input=0, mon_tick=0, busy=0, tick_miss=0.
REQ-031 Reset asserted mid-ISSUE or mid-WAIT SHALL discard buffered events and pending ticks with no further pulses.

Verification (PERIOD_CYCLES=10, GAP_CYCLES=3, FIFO_DEPTH=4)
REQ-032 Single event in_data=5 at edge N, idle -> mon_new_input=1, mon_input=5 in cycle N+1 only; busy high for 4 cycles.
REQ-033 Write 6 events back-to-back -> in_ready drops after 4 are buffered; all 6 values are issued in order, spaced exactly 4 cycles apart.
REQ-034 No events, en=1 -> mon_tick pulses every 10 cycles; first pulse 1 cycle after the 10th enabled edge.
REQ-035 Event and tick pending together -> a single slot with mon_new_input=1 and mon_tick=1.
REQ-036 en held 0 for 25 cycles with events buffered -> no pulses and timer frozen; resume exactly where stopped.
REQ-037 Force a tick miss (PERIOD_CYCLES=2, GAP_CYCLES=3) -> tick_miss pulses, miss_count increments and saturates at 255; rst low mid-WAIT clears all state per REQ-030.
